// File: rtl/hostif_irq_mailbox_pkg.sv
// ---------------------------------------------------------------------------
// hostif_irq_mailbox_pkg
// Shared definitions for the host interrupt mailbox:
//   - register word indexes (decoded from byte address bits [4:2])
//   - CTRL / STATUS bit positions and the CTRL register layout
//   - fill-level saturation helper for the STATUS level field
// ---------------------------------------------------------------------------
package hostif_irq_mailbox_pkg;

  // Register word indexes (byte offset >> 2)
  localparam logic [2:0] REG_ID        = 3'd0;  // 0x00
  localparam logic [2:0] REG_CTRL      = 3'd1;  // 0x04
  localparam logic [2:0] REG_STATUS    = 3'd2;  // 0x08
  localparam logic [2:0] REG_EVT_POP   = 3'd3;  // 0x0C
  localparam logic [2:0] REG_DOORBELL  = 3'd4;  // 0x10
  localparam logic [2:0] REG_IRQ_COUNT = 3'd5;  // 0x14

  // CTRL bit positions
  localparam int CTRL_IRQ_EN_BIT     = 0;
  localparam int CTRL_OVF_IRQ_EN_BIT = 1;

  // STATUS bit positions
  localparam int STATUS_NONEMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT     = 1;
  localparam int STATUS_OVF_BIT      = 2;
  localparam int STATUS_LEVEL_LSB    = 8;

  // CTRL register contents; packed so bit 0 is irq_en, bit 1 is ovf_irq_en
  typedef struct packed {
    logic ovf_irq_en;
    logic irq_en;
  } ctrl_t;

  // The STATUS level field is 8 bits; a 256-deep FIFO would otherwise wrap to 0
  function automatic logic [7:0] sat_level8(input logic [8:0] level);
    if (level > 9'd255) begin
      return 8'hFF;
    end else begin
      return level[7:0];
    end
  endfunction

endpackage

// File: rtl/hostif_irq_mailbox_if.sv
// ---------------------------------------------------------------------------
// hostif_irq_mailbox_if
// Avalon-MM bus bundle between the HPS lightweight bridge (master) and the
// mailbox (slave).
//   address/read/write/writedata/byteenable/burstcount/debugaccess : M -> S
//   readdata/readdatavalid/waitrequest                             : S -> M
// ---------------------------------------------------------------------------
interface hostif_irq_mailbox_if #(
  parameter int ADDR_W = 18
) ();

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic              burstcount;
  logic              debugaccess;
  logic [31:0]       readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, read, write, writedata, byteenable, burstcount, debugaccess,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable, burstcount, debugaccess,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/hostif_irq_mailbox_evt_fifo.sv
// ---------------------------------------------------------------------------
// hostif_evt_fifo
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push_i     : write wdata_i; accepted when not full, or when full and a
//                pop happens in the same cycle
//   pop_i      : drop head_o; ignored when empty
//   head_o     : oldest entry (valid only when !empty_o)
//   level_o    : number of stored entries (0..DEPTH)
//   full_o, empty_o
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module hostif_evt_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Qualify push/pop and compute next pointers; a pop frees the slot a full push needs
  always_comb begin
    do_pop_s  = pop_i & ~empty_o;
    do_push_s = push_i & (~full_o | do_pop_s);
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/hostif_irq_mailbox.sv
// ---------------------------------------------------------------------------
// hostif_irq_mailbox
// Avalon-MM slave behind the HPS lightweight bridge. FPGA logic pushes
// 32-bit events into a FIFO; the host pops them through EVT_POP, gets a
// level interrupt, and can ring a doorbell toward FPGA logic.
//   clk100_clk, reset_clk100_reset_n : clock, synchronous active-low reset
//   avs                : Avalon-MM slave bus (read latency fixed at 1)
//   evt_valid/evt_data : event push; evt_ready = FIFO not full
//   db_valid/db_data   : one-cycle doorbell pulse + last written payload
//   irq                : registered level interrupt
// ---------------------------------------------------------------------------
module hostif_irq_mailbox
  import hostif_irq_mailbox_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter int          ADDR_W     = 18,
  parameter logic [31:0] ID_VALUE   = 32'h4849_4631
) (
  input  logic                 clk100_clk,
  input  logic                 reset_clk100_reset_n,
  hostif_irq_mailbox_if.slave  avs,
  input  logic                 evt_valid,
  input  logic [31:0]          evt_data,
  output logic                 evt_ready,
  output logic                 db_valid,
  output logic [31:0]          db_data,
  output logic                 irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              waitreq_q, waitreq_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              ovf_q, ovf_d;
  logic              db_valid_q, db_valid_d;
  logic [31:0]       db_data_q, db_data_d;
  logic              irq_q, irq_d;
  logic [31:0]       irq_cnt_q, irq_cnt_d;

  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic [31:0]       fifo_head_s;
  logic [LVL_W-1:0]  fifo_level_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;

  logic              in_range_s;
  logic [2:0]        reg_idx_s;
  logic              rd_acc_s;
  logic              wr_acc_s;
  logic              ovf_set_s;
  logic [31:0]       status_s;
  logic [31:0]       rd_mux_s;

  // Burst count, debug access, upper byte lanes and byte-offset bits carry no meaning here
  logic unused_s;
  assign unused_s = ^{avs.burstcount, avs.debugaccess, avs.byteenable[3:1], avs.address[1:0]};

  hostif_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_evt_fifo (
    .clk     (clk100_clk),
    .rst_n   (reset_clk100_reset_n),
    .push_i  (fifo_push_s),
    .pop_i   (fifo_pop_s),
    .wdata_i (evt_data),
    .head_o  (fifo_head_s),
    .level_o (fifo_level_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Address decode and access qualification; a simultaneous write is dropped in favour of the read
  always_comb begin
    in_range_s  = (avs.address[ADDR_W-1:5] == {(ADDR_W-5){1'b0}});
    reg_idx_s   = avs.address[4:2];
    rd_acc_s    = avs.read & ~waitreq_q;
    wr_acc_s    = avs.write & ~avs.read & ~waitreq_q & in_range_s;
    fifo_pop_s  = rd_acc_s & in_range_s & (reg_idx_s == REG_EVT_POP);
    fifo_push_s = evt_valid & ~waitreq_q;
    // Full with a concurrent pop is not an overflow: the FIFO takes both
    ovf_set_s   = evt_valid & ~waitreq_q & fifo_full_s & ~fifo_pop_s;
  end

  // STATUS word assembly
  always_comb begin
    status_s                                = 32'd0;
    status_s[STATUS_NONEMPTY_BIT]           = ~fifo_empty_s;
    status_s[STATUS_FULL_BIT]               = fifo_full_s;
    status_s[STATUS_OVF_BIT]                = ovf_q;
    status_s[STATUS_LEVEL_LSB +: 8]         = sat_level8(9'(fifo_level_s));
  end

  // Read data multiplexer
  always_comb begin
    case (reg_idx_s)
      REG_ID:        rd_mux_s = ID_VALUE;
      REG_CTRL:      rd_mux_s = {30'd0, ctrl_q};
      REG_STATUS:    rd_mux_s = status_s;
      REG_EVT_POP:   rd_mux_s = fifo_empty_s ? 32'd0 : fifo_head_s;
      REG_DOORBELL:  rd_mux_s = db_data_q;
      REG_IRQ_COUNT: rd_mux_s = irq_cnt_q;
      default:       rd_mux_s = 32'd0;
    endcase
  end

  // Next-state logic for the read pipeline, registers, doorbell and interrupt
  always_comb begin
    waitreq_d = 1'b0;
    rvalid_d  = rd_acc_s;
    if (rd_acc_s && in_range_s) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = 32'd0;
    end

    ctrl_d = ctrl_q;
    if (wr_acc_s && (reg_idx_s == REG_CTRL) && avs.byteenable[0]) begin
      ctrl_d.irq_en     = avs.writedata[CTRL_IRQ_EN_BIT];
      ctrl_d.ovf_irq_en = avs.writedata[CTRL_OVF_IRQ_EN_BIT];
    end else begin
      ctrl_d = ctrl_q;
    end

    // A new overflow in the clearing cycle wins so no drop goes unreported
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (wr_acc_s && (reg_idx_s == REG_STATUS) && avs.byteenable[0] &&
                 avs.writedata[STATUS_OVF_BIT]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    db_valid_d = wr_acc_s && (reg_idx_s == REG_DOORBELL);
    if (db_valid_d) begin
      db_data_d = avs.writedata;
    end else begin
      db_data_d = db_data_q;
    end

    // Uses the next CTRL value so disabling takes effect on the following cycle
    irq_d = (ctrl_d.irq_en & ~fifo_empty_s) | (ctrl_d.ovf_irq_en & ovf_q);

    if (wr_acc_s && (reg_idx_s == REG_IRQ_COUNT)) begin
      irq_cnt_d = 32'd0;
    end else if (irq_d && !irq_q) begin
      irq_cnt_d = irq_cnt_q + 32'd1;
    end else begin
      irq_cnt_d = irq_cnt_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk100_clk) begin
    if (!reset_clk100_reset_n) begin
      waitreq_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
      ctrl_q     <= '0;
      ovf_q      <= 1'b0;
      db_valid_q <= 1'b0;
      db_data_q  <= 32'd0;
      irq_q      <= 1'b0;
      irq_cnt_q  <= 32'd0;
    end else begin
      waitreq_q  <= waitreq_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      db_valid_q <= db_valid_d;
      db_data_q  <= db_data_d;
      irq_q      <= irq_d;
      irq_cnt_q  <= irq_cnt_d;
    end
  end

  // Gating with reset cancels a response already in flight when reset arrives
  assign avs.waitrequest   = waitreq_q;
  assign avs.readdatavalid = rvalid_q & reset_clk100_reset_n;
  assign avs.readdata      = rdata_q & {32{rvalid_q & reset_clk100_reset_n}};
  assign evt_ready         = ~waitreq_q & ~fifo_full_s & reset_clk100_reset_n;
  assign db_valid          = db_valid_q;
  assign db_data           = db_data_q;
  assign irq               = irq_q;

endmodule

// File: tb/tb_hostif_irq_mailbox.sv
// ---------------------------------------------------------------------------
// tb_hostif_irq_mailbox
// Directed bench for hostif_irq_mailbox. Every read issued pushes its
// expected data into exp_q; a negedge monitor pops and compares whenever
// readdatavalid is seen. Side-band outputs (irq, doorbell, waitrequest,
// evt_ready) are checked directly one time unit after the clock edge.
// ---------------------------------------------------------------------------
module tb_hostif_irq_mailbox;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        evt_valid;
  logic [31:0] evt_data;
  logic        evt_ready;
  logic        db_valid;
  logic [31:0] db_data;
  logic        irq;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [$];

  hostif_irq_mailbox_if #(.ADDR_W(ADDR_W)) avs_if ();

  hostif_irq_mailbox #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (ADDR_W),
    .ID_VALUE   (32'h4849_4631)
  ) dut (
    .clk100_clk           (clk),
    .reset_clk100_reset_n (rst_n),
    .avs                  (avs_if),
    .evt_valid            (evt_valid),
    .evt_data             (evt_data),
    .evt_ready            (evt_ready),
    .db_valid             (db_valid),
    .db_data              (db_data),
    .irq                  (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] e);
    avs_if.read    = 1'b1;
    avs_if.address = a;
    exp_q.push_back(e);
    tick();
    avs_if.read = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_if.write      = 1'b1;
    avs_if.address    = a;
    avs_if.writedata  = d;
    avs_if.byteenable = be;
    tick();
    avs_if.write = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    evt_valid = 1'b1;
    evt_data  = d;
    tick();
    evt_valid = 1'b0;
  endtask

  // Scoreboard monitor: compare every read response against the oldest expectation
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (avs_if.readdatavalid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rdata_unexpected: got readdatavalid=1 data 0x%08h, expected no response",
                 avs_if.readdata);
      end else begin
        e = exp_q.pop_front();
        if (avs_if.readdata !== e) begin
          n_fail++;
          $display("FAIL rdata: got 0x%08h, expected 0x%08h", avs_if.readdata, e);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    avs_if.address     = '0;
    avs_if.read        = 1'b0;
    avs_if.write       = 1'b0;
    avs_if.writedata   = 32'd0;
    avs_if.byteenable  = 4'h0;
    avs_if.burstcount  = 1'b0;
    avs_if.debugaccess = 1'b0;
    evt_valid          = 1'b0;
    evt_data           = 32'd0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_waitrequest", 32'(avs_if.waitrequest), 32'd1);
    chk("rst_rdvalid",     32'(avs_if.readdatavalid), 32'd0);
    chk("rst_readdata",    avs_if.readdata, 32'd0);
    chk("rst_evt_ready",   32'(evt_ready), 32'd0);
    chk("rst_irq",         32'(irq), 32'd0);
    chk("rst_db_valid",    32'(db_valid), 32'd0);
    chk("rst_db_data",     db_data, 32'd0);

    // First edge after release
    rst_n = 1'b1;
    tick();
    chk("post_rst_waitrequest", 32'(avs_if.waitrequest), 32'd0);
    chk("post_rst_evt_ready",   32'(evt_ready), 32'd1);
    rd(18'h00, 32'h4849_4631);

    // Interrupt on events
    wr(18'h04, 32'h0000_0001, 4'h1);
    push(32'h0000_00A1);
    chk("irq_1cyc_after_push", 32'(irq), 32'd0);
    push(32'h0000_00A2);
    chk("irq_2cyc_after_push", 32'(irq), 32'd1);
    rd(18'h08, 32'h0000_0201);
    rd(18'h0C, 32'h0000_00A1);
    rd(18'h0C, 32'h0000_00A2);
    chk("irq_1cyc_after_pop", 32'(irq), 32'd1);
    tick();
    chk("irq_2cyc_after_pop", 32'(irq), 32'd0);
    rd(18'h14, 32'd1);

    // Overflow: 17 pushes into a 16-deep FIFO
    evt_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      evt_data = 32'(i);
      tick();
    end
    evt_valid = 1'b0;
    chk("full_evt_ready", 32'(evt_ready), 32'd0);
    rd(18'h08, 32'h0000_1007);
    wr(18'h08, 32'h0000_0004, 4'h1);
    rd(18'h08, 32'h0000_1003);
    rd(18'h14, 32'd2);
    for (int i = 1; i <= 16; i++) begin
      rd(18'h0C, 32'(i));
    end
    rd(18'h08, 32'h0000_0000);

    // Full FIFO: push and pop in the same cycle
    evt_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      evt_data = 32'h100 + 32'(i);
      tick();
    end
    evt_data       = 32'h0000_BEEF;
    avs_if.read    = 1'b1;
    avs_if.address = 18'h0C;
    exp_q.push_back(32'h0000_0100);
    tick();
    evt_valid   = 1'b0;
    avs_if.read = 1'b0;
    rd(18'h08, 32'h0000_1003);
    for (int i = 1; i < 16; i++) begin
      rd(18'h0C, 32'h100 + 32'(i));
    end
    rd(18'h0C, 32'h0000_BEEF);
    rd(18'h0C, 32'h0000_0000);

    // Empty FIFO: push and pop in the same cycle
    evt_valid      = 1'b1;
    evt_data       = 32'h0000_0077;
    avs_if.read    = 1'b1;
    avs_if.address = 18'h0C;
    exp_q.push_back(32'h0000_0000);
    tick();
    evt_valid   = 1'b0;
    avs_if.read = 1'b0;
    rd(18'h0C, 32'h0000_0077);

    // Doorbell
    wr(18'h10, 32'hDEAD_BEEF, 4'h0);
    chk("db_valid_pulse", 32'(db_valid), 32'd1);
    chk("db_data",        db_data, 32'hDEAD_BEEF);
    tick();
    chk("db_valid_single", 32'(db_valid), 32'd0);
    rd(18'h10, 32'hDEAD_BEEF);

    // Read and write together: read wins, write dropped
    avs_if.read       = 1'b1;
    avs_if.write      = 1'b1;
    avs_if.address    = 18'h04;
    avs_if.writedata  = 32'h0000_0003;
    avs_if.byteenable = 4'hF;
    exp_q.push_back(32'h0000_0001);
    tick();
    avs_if.read  = 1'b0;
    avs_if.write = 1'b0;
    rd(18'h04, 32'h0000_0001);

    // Out-of-range accesses
    wr(18'h24, 32'h0000_0000, 4'hF);
    rd(18'h04, 32'h0000_0001);
    rd(18'h20, 32'h0000_0000);

    // IRQ_COUNT cleared by any write (4 rising edges so far)
    rd(18'h14, 32'd4);
    wr(18'h14, 32'h0000_FFFF, 4'h0);
    rd(18'h14, 32'd0);

    // Reset while a read response is pending
    push(32'h0000_0055);
    tick();
    chk("irq_before_reset", 32'(irq), 32'd1);
    avs_if.read    = 1'b1;
    avs_if.address = 18'h00;
    tick();
    avs_if.read = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("rdvalid_cancelled", 32'(avs_if.readdatavalid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("irq_after_reset",         32'(irq), 32'd0);
    chk("waitrequest_after_reset", 32'(avs_if.waitrequest), 32'd0);
    rd(18'h08, 32'h0000_0000);
    rd(18'h20, 32'h0000_0000);
    rd(18'h04, 32'h0000_0000);

    tick();
    tick();
    chk("responses_outstanding", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
